minibyte_alu_seq: RTL

Parametrised, multi-cycle successor to the minibyte combinational ALU. It keeps the same op encoding and adds registered outputs and a start/busy/done handshake. Shifts run iteratively, one bit position per cycle, and an optional iterative shift-add multiply is available. It also adds carry and overflow flags. It sits between the register file operand muxes and the writeback/flag registers and lets the control FSM stall on busy_out.

---
 rtl/minibyte_alu_seq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/minibyte_alu_seq.sv
// Multi-cycle minibyte ALU: registered results/flags, start/busy/done handshake, iterative shifts.
// Define MINIBYTE_ALU_MUL_EN to build the iterative shift-add multiplier for op 1011.
//
// state | meaning
// IDLE  | accepting start_in; single-cycle ops complete from here
// RUN   | iterating a shift (one bit per cycle) or a multiply step
module minibyte_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       alu_op_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] res_out,
  output logic             flag_z_out,
  output logic             flag_n_out,
  output logic             flag_c_out,
  output logic             flag_v_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] K_MAX = CNT_W'(WIDTH);

  localparam logic [3:0] OP_PASSA = 4'h0, OP_PASSB = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_OR = 4'h5, OP_XOR = 4'h6, OP_LSL = 4'h7;
  localparam logic [3:0] OP_LSR = 4'h8, OP_ASL = 4'h9, OP_ASR = 4'hA, OP_MUL = 4'hB;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_nx;

  logic [3:0]       op_q, op_nx;
  logic [WIDTH-1:0] sh_q, sh_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [WIDTH-1:0] res_q, res_nx;
  logic             z_q, z_nx, n_q, n_nx, c_q, c_nx, v_q, v_nx;
  logic             done_q, done_nx;
  logic             step_out;

  logic             is_sub, is_shift;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_sum;
  logic [CNT_W-1:0] k;

`ifdef MINIBYTE_ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_nx, hi_q, hi_nx;
  logic [WIDTH:0]   mul_sum;
`endif

  always_comb begin
    is_sub   = (alu_op_in == OP_SUB);
    is_shift = (alu_op_in == OP_LSL) || (alu_op_in == OP_LSR) ||
               (alu_op_in == OP_ASL) || (alu_op_in == OP_ASR);
    b_eff    = is_sub ? ~b_in : b_in;
    add_sum  = {1'b0, a_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    // Shift count saturates at WIDTH; any high bit set already exceeds it.
    if ((|b_in[WIDTH-1:CNT_W]) || (b_in[CNT_W-1:0] >= K_MAX)) k = K_MAX;
    else                                                      k = b_in[CNT_W-1:0];
  end

  always_comb begin
    state_nx = state_q;
    op_nx    = op_q;
    sh_nx    = sh_q;
    cnt_nx   = cnt_q;
    res_nx   = res_q;
    z_nx     = z_q;
    n_nx     = n_q;
    c_nx     = c_q;
    v_nx     = v_q;
    done_nx  = 1'b0;
    step_out = 1'b0;
`ifdef MINIBYTE_ALU_MUL_EN
    mcand_nx = mcand_q;
    hi_nx    = hi_q;
    mul_sum  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (start_in) begin
          op_nx = alu_op_in;
          if (is_shift && (k != '0)) begin
            state_nx = RUN;
            sh_nx    = a_in;
            cnt_nx   = k;
          end
`ifdef MINIBYTE_ALU_MUL_EN
          else if (alu_op_in == OP_MUL) begin
            state_nx = RUN;
            sh_nx    = b_in;
            mcand_nx = a_in;
            hi_nx    = '0;
            cnt_nx   = K_MAX;
          end
`endif
          else begin
            done_nx = 1'b1;
            c_nx    = 1'b0;
            v_nx    = 1'b0;
            case (alu_op_in)
              OP_PASSA: res_nx = a_in;
              OP_PASSB: res_nx = b_in;
              OP_ADD, OP_SUB: begin
                res_nx = add_sum[WIDTH-1:0];
                c_nx   = add_sum[WIDTH];
                v_nx   = (a_in[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != a_in[WIDTH-1]);
              end
              OP_AND: res_nx = a_in & b_in;
              OP_OR:  res_nx = a_in | b_in;
              OP_XOR: res_nx = a_in ^ b_in;
              OP_LSL, OP_LSR, OP_ASL, OP_ASR: res_nx = a_in;
              default: res_nx = '0;
            endcase
          end
        end
      end
      RUN: begin
        cnt_nx = cnt_q - CNT_W'(1);
        case (op_q)
          OP_LSL, OP_ASL: begin
            sh_nx    = {sh_q[WIDTH-2:0], 1'b0};
            step_out = sh_q[WIDTH-1];
          end
          OP_LSR: begin
            sh_nx    = {1'b0, sh_q[WIDTH-1:1]};
            step_out = sh_q[0];
          end
          OP_ASR: begin
            sh_nx    = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
            step_out = sh_q[0];
          end
`ifdef MINIBYTE_ALU_MUL_EN
          // {hi, sh} shifts right as a 2*WIDTH product; sh starts as the multiplier.
          OP_MUL: begin
            mul_sum  = {1'b0, hi_q} + (sh_q[0] ? {1'b0, mcand_q} : '0);
            hi_nx    = mul_sum[WIDTH:1];
            sh_nx    = {mul_sum[0], sh_q[WIDTH-1:1]};
            step_out = |mul_sum[WIDTH:1];
          end
`endif
          default: ;
        endcase
        if (cnt_q == CNT_W'(1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          res_nx   = sh_nx;
          c_nx     = step_out;
          v_nx     = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (done_nx) begin
      z_nx = (res_nx == '0);
      n_nx = res_nx[WIDTH-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      op_q    <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
`ifdef MINIBYTE_ALU_MUL_EN
      mcand_q <= '0;
      hi_q    <= '0;
`endif
    end else begin
      state_q <= state_nx;
      op_q    <= op_nx;
      sh_q    <= sh_nx;
      cnt_q   <= cnt_nx;
      res_q   <= res_nx;
      z_q     <= z_nx;
      n_q     <= n_nx;
      c_q     <= c_nx;
      v_q     <= v_nx;
      done_q  <= done_nx;
`ifdef MINIBYTE_ALU_MUL_EN
      mcand_q <= mcand_nx;
      hi_q    <= hi_nx;
`endif
    end
  end

  assign busy_out   = (state_q == RUN);
  assign done_out   = done_q;
  assign res_out    = res_q;
  assign flag_z_out = z_q;
  assign flag_n_out = n_q;
  assign flag_c_out = c_q;
  assign flag_v_out = v_q;

endmodule
